// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-master RAM arbiter: FSM state encodings
// and the default RAM access latency.
package ram_arbiter_pkg;
   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_DONE   = 2'd2
   } arb_state_t;

   localparam int RAM_LAT_DEF = 2;
   // Wide enough for the largest legal latency (15).
   localparam int CNT_W       = 4;
endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins; on a tie the
// pointer selects the winner.
module rr_pick2 (
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_ptr,
   output logic o_winner,
   output logic o_valid
);
   always_comb begin
      o_valid  = i_req0 | i_req1;
      o_winner = 1'b0;
      if (i_req0 && i_req1)
         o_winner = i_ptr;
      else
         o_winner = i_req1;
   end
endmodule

// File: rtl/ram_arbiter.sv
// Shares one data-RAM port between the CPU control unit (master 0) and the
// I/O/DMA port (master 1); one transaction in flight, fixed RAM latency.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int DATA_W  = 14,
   parameter int ADDR_W  = 12,
   parameter int RAM_LAT = RAM_LAT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_wr,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_done,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_wr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_done,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              ram_rd,
   output logic              ram_wr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              owner
);
   arb_state_t        r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ptr;
   logic              r_owner;
   logic              r_rd, r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata0, r_rdata1;
   logic              r_gnt0, r_gnt1, r_done0, r_done1;

   logic              w_winner, w_valid;
   logic              w_grant, w_finish, w_dec, w_turn;
   logic              w_sel_wr;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;

   rr_pick2 u_pick (
      .i_req0   (m0_req),
      .i_req1   (m1_req),
      .i_ptr    (r_ptr),
      .o_winner (w_winner),
      .o_valid  (w_valid)
   );

   assign w_sel_wr    = w_winner ? m1_wr    : m0_wr;
   assign w_sel_addr  = w_winner ? m1_addr  : m0_addr;
   assign w_sel_wdata = w_winner ? m1_wdata : m0_wdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= ARB_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_finish    = 1'b0;
      w_dec       = 1'b0;
      w_turn      = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_valid) begin
               w_grant     = 1'b1;
               w_state_nxt = ARB_ACCESS;
            end
         end
         ARB_ACCESS: begin
            if (r_cnt == '0) begin
               w_finish    = 1'b1;
               w_state_nxt = ARB_DONE;
            end else begin
               w_dec = 1'b1;
            end
         end
         ARB_DONE: begin
            w_turn      = 1'b1;
            w_state_nxt = ARB_IDLE;
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   // The RAM bus registers and read data are cleared on reset too, so a
   // dropped transaction leaves nothing visible behind.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_ptr    <= 1'b0;
         r_owner  <= 1'b0;
         r_rd     <= 1'b0;
         r_wr     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
         r_gnt0   <= 1'b0;
         r_gnt1   <= 1'b0;
         r_done0  <= 1'b0;
         r_done1  <= 1'b0;
      end else begin
         r_gnt0  <= w_grant & ~w_winner;
         r_gnt1  <= w_grant &  w_winner;
         r_done0 <= w_finish & ~r_owner;
         r_done1 <= w_finish &  r_owner;
         if (w_grant) begin
            r_owner <= w_winner;
            r_rd    <= ~w_sel_wr;
            r_wr    <=  w_sel_wr;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_cnt   <= CNT_W'(RAM_LAT - 1);
         end else if (w_finish) begin
            r_rd <= 1'b0;
            r_wr <= 1'b0;
            if (r_rd) begin
               if (r_owner)
                  r_rdata1 <= ram_rdata;
               else
                  r_rdata0 <= ram_rdata;
            end
         end else if (w_dec) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         // Hand the next tie to whoever did not just finish.
         if (w_turn)
            r_ptr <= ~r_owner;
      end
   end

   assign m0_gnt    = r_gnt0;
   assign m1_gnt    = r_gnt1;
   assign m0_done   = r_done0;
   assign m1_done   = r_done1;
   assign m0_rdata  = r_rdata0;
   assign m1_rdata  = r_rdata1;
   assign ram_rd    = r_rd;
   assign ram_wr    = r_wr;
   assign ram_addr  = r_addr;
   assign ram_wdata = r_wdata;
   assign busy      = (r_state != ARB_IDLE);
   assign owner     = r_owner;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a RAM_LAT=2 instance for the main scenarios
// and a RAM_LAT=1 instance for the short-latency, early-drop case.
module tb_ram_arbiter;
   localparam int DATA_W = 14;
   localparam int ADDR_W = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic              m0_req, m0_wr, m0_gnt, m0_done;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata, m0_rdata;
   logic              m1_req, m1_wr, m1_gnt, m1_done;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata, m1_rdata;
   logic              ram_rd, ram_wr, busy, owner;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;

   logic              b0_req, b0_wr, b0_gnt, b0_done;
   logic [ADDR_W-1:0] b0_addr;
   logic [DATA_W-1:0] b0_wdata, b0_rdata;
   logic              b1_req, b1_wr, b1_gnt, b1_done;
   logic [ADDR_W-1:0] b1_addr;
   logic [DATA_W-1:0] b1_wdata, b1_rdata;
   logic              b_ram_rd, b_ram_wr, b_busy, b_owner;
   logic [ADDR_W-1:0] b_ram_addr;
   logic [DATA_W-1:0] b_ram_wdata, b_ram_rdata;

   ram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_LAT(2)) u_dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
      .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
   );

   ram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_LAT(1)) u_dut_lat1 (
      .clk(clk), .reset(reset),
      .m0_req(b0_req), .m0_wr(b0_wr), .m0_addr(b0_addr), .m0_wdata(b0_wdata),
      .m0_gnt(b0_gnt), .m0_done(b0_done), .m0_rdata(b0_rdata),
      .m1_req(b1_req), .m1_wr(b1_wr), .m1_addr(b1_addr), .m1_wdata(b1_wdata),
      .m1_gnt(b1_gnt), .m1_done(b1_done), .m1_rdata(b1_rdata),
      .ram_rd(b_ram_rd), .ram_wr(b_ram_wr), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
      .ram_rdata(b_ram_rdata), .busy(b_busy), .owner(b_owner)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int n_excl   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (ram_rd && ram_wr)     n_excl++;
         if (m0_gnt && m1_gnt)     n_excl++;
         if (m0_done && m1_done)   n_excl++;
         if (b_ram_rd && b_ram_wr) n_excl++;
      end
   end

   initial begin
      int order[$];
      int ndone;

      reset = 1'b0;
      m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 12'h123; m0_wdata = '0;
      m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0;     m1_wdata = '0;
      ram_rdata = 14'h1ABC;
      b0_req = 1'b0; b0_wr = 1'b0; b0_addr = '0; b0_wdata = '0;
      b1_req = 1'b0; b1_wr = 1'b0; b1_addr = '0; b1_wdata = '0;
      b_ram_rdata = '0;

      // Reset held with a pending request
      tick(); tick(); tick();
      check_eq("rst_gnt0", m0_gnt, 0);
      check_eq("rst_ram_rd", ram_rd, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_owner", owner, 0);
      check_eq("rst_rdata0", m0_rdata, 0);
      check_eq("rst_addr", ram_addr, 0);
      reset = 1'b1;

      // Single read by m0
      tick();
      check_eq("rd_gnt0", m0_gnt, 1);
      check_eq("rd_gnt1", m1_gnt, 0);
      check_eq("rd_strobe1", ram_rd, 1);
      check_eq("rd_addr", ram_addr, 12'h123);
      check_eq("rd_busy", busy, 1);
      check_eq("rd_owner", owner, 0);
      tick();
      check_eq("rd_gnt_pulse", m0_gnt, 0);
      check_eq("rd_strobe2", ram_rd, 1);
      tick();
      check_eq("rd_strobe_off", ram_rd, 0);
      check_eq("rd_done0", m0_done, 1);
      check_eq("rd_rdata0", m0_rdata, 14'h1ABC);
      check_eq("rd_rdata1", m1_rdata, 0);
      m0_req = 1'b0;
      tick();
      check_eq("rd_done_pulse", m0_done, 0);
      check_eq("rd_idle", busy, 0);

      // Single write by m1
      m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 12'h0FF; m1_wdata = 14'h2A5A;
      ram_rdata = 14'h3333;
      tick();
      check_eq("wr_gnt1", m1_gnt, 1);
      check_eq("wr_strobe1", ram_wr, 1);
      check_eq("wr_no_rd", ram_rd, 0);
      check_eq("wr_addr", ram_addr, 12'h0FF);
      check_eq("wr_wdata", ram_wdata, 14'h2A5A);
      check_eq("wr_owner", owner, 1);
      tick();
      check_eq("wr_strobe2", ram_wr, 1);
      tick();
      check_eq("wr_done1", m1_done, 1);
      check_eq("wr_strobe_off", ram_wr, 0);
      check_eq("wr_rdata1", m1_rdata, 0);
      check_eq("wr_rdata0", m0_rdata, 14'h1ABC);
      m1_req = 1'b0; m1_wr = 1'b0;
      tick();

      // Contention: both requesting continuously
      m0_req = 1'b1; m0_addr = 12'h010;
      m1_req = 1'b1; m1_addr = 12'h020;
      ndone = 0;
      for (int c = 0; c < 40 && ndone < 4; c++) begin
         tick();
         if (m0_gnt) order.push_back(0);
         if (m1_gnt) order.push_back(1);
         if (m0_done || m1_done) begin
            ndone++;
            if (ndone == 4) begin
               m0_req = 1'b0;
               m1_req = 1'b0;
            end
         end
      end
      check_eq("cont_ndone", ndone, 4);
      check_eq("cont_ngnt", order.size(), 4);
      for (int i = 0; i < 4; i++)
         check_eq($sformatf("cont_gnt%0d", i), (i < order.size()) ? order[i] : 99, i % 2);
      tick();

      // Reset in the middle of an access
      m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 12'h055;
      ram_rdata = 14'h0777;
      tick();
      check_eq("mr_gnt0", m0_gnt, 1);
      tick();
      check_eq("mr_strobe", ram_rd, 1);
      reset = 1'b0;
      #1;
      check_eq("mr_strobe_drop", ram_rd, 0);
      check_eq("mr_busy_drop", busy, 0);
      tick();
      check_eq("mr_no_done", m0_done, 0);
      reset = 1'b1;
      tick();
      check_eq("mr_regnt0", m0_gnt, 1);
      tick();
      check_eq("mr_no_done2", m0_done, 0);
      tick();
      check_eq("mr_done0", m0_done, 1);
      check_eq("mr_rdata0", m0_rdata, 14'h0777);
      m0_req = 1'b0;
      tick();

      // Lone m0 request while the pointer favours m1
      m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 12'h010; m0_wdata = 14'h1111;
      tick();
      check_eq("lone_gnt0", m0_gnt, 1);
      check_eq("lone_gnt1", m1_gnt, 0);
      check_eq("lone_wr", ram_wr, 1);
      tick(); tick();
      check_eq("lone_done0", m0_done, 1);
      check_eq("lone_rdata0", m0_rdata, 14'h0777);
      m0_req = 1'b0; m0_wr = 1'b0;
      tick();

      // RAM_LAT = 1 with an early request drop
      b0_req = 1'b1; b0_wr = 1'b0; b0_addr = 12'h200;
      b_ram_rdata = 14'h0421;
      tick();
      check_eq("l1_gnt0", b0_gnt, 1);
      check_eq("l1_strobe", b_ram_rd, 1);
      check_eq("l1_addr", b_ram_addr, 12'h200);
      b0_req = 1'b0;
      tick();
      check_eq("l1_done0", b0_done, 1);
      check_eq("l1_strobe_off", b_ram_rd, 0);
      check_eq("l1_rdata0", b0_rdata, 14'h0421);
      tick();
      check_eq("l1_done_pulse", b0_done, 0);
      tick();
      check_eq("l1_idle", b_busy, 0);
      check_eq("l1_no_regnt", b0_gnt, 0);

      check_eq("exclusivity", n_excl, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
